// File: rtl/an_code_pkg.sv
// ---------------------------------------------------------------------------
// an_code_pkg
// Shared constants and helpers for the AN-code (A=13) decoder.
//   A, BARRETT_M, BARRETT_S : code multiplier and Barrett reduction constants
//   MAX_CW                  : largest legal codeword (13*7)
//   anStatus_e              : result status (CLEAN / CORR / UNCORR)
//   syndromeOffset()        : residue -> signed single-error offset
// ---------------------------------------------------------------------------
package an_code_pkg;

    localparam int A         = 13;
    localparam int BARRETT_M = 19;
    localparam int BARRETT_S = 8;
    localparam int MAX_CW    = 91;

    typedef enum logic [1:0] {
        CLEAN  = 2'b00,
        CORR   = 2'b01,
        UNCORR = 2'b10
    } anStatus_e;

    // Each nonzero residue mod 13 maps to exactly one error of the form
    // +/-2^i with i in 0..5, so the table is a complete syndrome decode.
    function automatic logic signed [7:0] syndromeOffset(input logic [3:0] r);
        logic signed [7:0] e;
        case (r)
            4'd1:    e = 8'sd1;
            4'd2:    e = 8'sd2;
            4'd4:    e = 8'sd4;
            4'd8:    e = 8'sd8;
            4'd3:    e = 8'sd16;
            4'd6:    e = 8'sd32;
            4'd12:   e = -8'sd1;
            4'd11:   e = -8'sd2;
            4'd9:    e = -8'sd4;
            4'd5:    e = -8'sd8;
            4'd10:   e = -8'sd16;
            4'd7:    e = -8'sd32;
            default: e = 8'sd0;
        endcase
        return e;
    endfunction

endpackage

// File: rtl/an_decode_arbiter_if.sv
// ---------------------------------------------------------------------------
// an_decode_arbiter_if
// Request / result / statistics bundle of the shared AN decoder.
//   req_valid, req_codeword, req_ready : per-requester codeword handshake
//   out_valid, out_ready, out_id, out_message, out_status : result handshake
//   cnt_clr, corr_cnt, uncorr_cnt      : statistics counters
// modport slave  : decoder side
// modport master : requester / consumer side
// ---------------------------------------------------------------------------
interface an_decode_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int CW_W  = 7,
    parameter int MSG_W = 3,
    parameter int CNT_W = 16
);

    logic [NREQ-1:0]         req_valid;
    logic [NREQ*CW_W-1:0]    req_codeword;
    logic [NREQ-1:0]         req_ready;
    logic                    out_valid;
    logic                    out_ready;
    logic [$clog2(NREQ)-1:0] out_id;
    logic [MSG_W-1:0]        out_message;
    logic [1:0]              out_status;
    logic                    cnt_clr;
    logic [CNT_W-1:0]        corr_cnt;
    logic [CNT_W-1:0]        uncorr_cnt;

    modport slave (
        input  req_valid, req_codeword, out_ready, cnt_clr,
        output req_ready, out_valid, out_id, out_message, out_status,
               corr_cnt, uncorr_cnt
    );

    modport master (
        output req_valid, req_codeword, out_ready, cnt_clr,
        input  req_ready, out_valid, out_id, out_message, out_status,
               corr_cnt, uncorr_cnt
    );

endinterface

// File: rtl/an_barrett_residue.sv
// ---------------------------------------------------------------------------
// an_barrett_residue
// Two registered stages computing x mod 13 by Barrett reduction.
//   clk, rst : clock, asynchronous active-high reset
//   en_i     : advance both stages
//   x_i      : codeword entering stage 1
//   r_o      : residue x mod 13 (stage 2)
//   x_o      : codeword delayed to line up with r_o
// ---------------------------------------------------------------------------
module an_barrett_residue
    import an_code_pkg::*;
#(
    parameter int CW_W = 7
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en_i,
    input  logic [CW_W-1:0] x_i,
    output logic [3:0]      r_o,
    output logic [CW_W-1:0] x_o
);

    localparam int PROD_W = CW_W + 5;

    logic [PROD_W-1:0] prod;
    logic [CW_W-1:0]   q_d;
    logic [CW_W-1:0]   rRaw;
    logic [CW_W-1:0]   rFix;
    logic [3:0]        r_d;
    logic [CW_W-1:0]   x1_q;
    logic [CW_W-1:0]   q1_q;
    logic [3:0]        r2_q;
    logic [CW_W-1:0]   x2_q;

    // 19/256 slightly underestimates 1/13, so q is never too large and the
    // raw remainder is non-negative; one subtract brings it below 13.
    always_comb begin
        prod = PROD_W'(x_i) * PROD_W'(BARRETT_M);
        q_d  = CW_W'(prod >> BARRETT_S);
        rRaw = x1_q - CW_W'(q1_q * CW_W'(A));
        rFix = (rRaw >= CW_W'(A)) ? (rRaw - CW_W'(A)) : rRaw;
        r_d  = 4'(rFix);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x1_q <= '0;
            q1_q <= '0;
            r2_q <= '0;
            x2_q <= '0;
        end else if (en_i) begin
            x1_q <= x_i;
            q1_q <= q_d;
            r2_q <= r_d;
            x2_q <= x1_q;
        end
    end

    assign r_o = r2_q;
    assign x_o = x2_q;

endmodule

// File: rtl/an_decode_arbiter.sv
// ---------------------------------------------------------------------------
// an_decode_arbiter
// Round-robin shares one 3-stage AN-code (A=13) decoder among NREQ requesters.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : an_decode_arbiter_if.slave
//              req_valid/req_codeword/req_ready : per-requester input
//              out_valid/out_ready/out_id/out_message/out_status : result
//              cnt_clr/corr_cnt/uncorr_cnt : saturating statistics
// ---------------------------------------------------------------------------
module an_decode_arbiter
    import an_code_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int CW_W  = 7,
    parameter int MSG_W = 3,
    parameter int CNT_W = 16
) (
    input logic                clk,
    input logic                rst,
    an_decode_arbiter_if.slave bus
);

    localparam int ID_W = $clog2(NREQ);
    localparam int Y_W  = CW_W + 2;
    localparam logic [CNT_W-1:0]      CNT_MAX = '1;
    localparam logic signed [Y_W-1:0] Y_MAX   = Y_W'(MAX_CW);

    logic                    adv;
    logic                    accept;
    logic                    xfer;
    logic                    grantFound;
    logic [ID_W-1:0]         grantId;
    logic [NREQ-1:0]         reqReady;
    logic [CW_W-1:0]         grantCw;
    logic [ID_W-1:0]         rrPtr_q;
    logic [ID_W-1:0]         rrPtr_d;
    logic                    s1Valid_q;
    logic [ID_W-1:0]         s1Id_q;
    logic                    s2Valid_q;
    logic [ID_W-1:0]         s2Id_q;
    logic [3:0]              s2Residue;
    logic [CW_W-1:0]         s2Cw;
    logic signed [7:0]       synOffset;
    logic signed [Y_W-1:0]   yVal;
    anStatus_e               status_d;
    logic [MSG_W-1:0]        msg_d;
    logic                    outValid_q;
    logic [ID_W-1:0]         outId_q;
    logic [MSG_W-1:0]        outMsg_q;
    anStatus_e               outStatus_q;
    logic [CNT_W-1:0]        corrCnt_q;
    logic [CNT_W-1:0]        uncorrCnt_q;

    assign adv  = !outValid_q || bus.out_ready;
    assign xfer = outValid_q && bus.out_ready;

    // First requesting index at or above the pointer, wrapping around.
    always_comb begin
        int idx;
        idx        = 0;
        grantFound = 1'b0;
        grantId    = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(rrPtr_q) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!grantFound && bus.req_valid[idx]) begin
                grantFound = 1'b1;
                grantId    = ID_W'(idx);
            end
        end
    end

    assign accept  = adv && grantFound;
    assign rrPtr_d = (int'(grantId) == NREQ - 1) ? '0 : grantId + 1'b1;
    assign grantCw = bus.req_codeword[int'(grantId)*CW_W +: CW_W];

    always_comb begin
        reqReady = '0;
        if (accept) reqReady[grantId] = 1'b1;
    end

    an_barrett_residue #(
        .CW_W (CW_W)
    ) u_residue (
        .clk  (clk),
        .rst  (rst),
        .en_i (adv),
        .x_i  (grantCw),
        .r_o  (s2Residue),
        .x_o  (s2Cw)
    );

    // Undo the error implied by the residue; a "correction" landing outside
    // the legal codeword range means the error was not a single +/-2^i.
    always_comb begin
        synOffset = syndromeOffset(s2Residue);
        yVal      = $signed({2'b00, s2Cw}) - Y_W'(synOffset);
        msg_d     = '0;
        if (s2Residue == 4'd0)
            status_d = CLEAN;
        else if (yVal < 0 || yVal > Y_MAX)
            status_d = UNCORR;
        else
            status_d = CORR;
        if (status_d != UNCORR)
            msg_d = MSG_W'($unsigned(yVal) / Y_W'(A));
    end

    // All stages shift together; a stalled output freezes the whole pipe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rrPtr_q     <= '0;
            s1Valid_q   <= 1'b0;
            s1Id_q      <= '0;
            s2Valid_q   <= 1'b0;
            s2Id_q      <= '0;
            outValid_q  <= 1'b0;
            outId_q     <= '0;
            outMsg_q    <= '0;
            outStatus_q <= CLEAN;
        end else if (adv) begin
            if (accept) rrPtr_q <= rrPtr_d;
            s1Valid_q   <= accept;
            s1Id_q      <= grantId;
            s2Valid_q   <= s1Valid_q;
            s2Id_q      <= s1Id_q;
            outValid_q  <= s2Valid_q;
            outId_q     <= s2Id_q;
            outMsg_q    <= msg_d;
            outStatus_q <= status_d;
        end
    end

    // Statistics count only results actually handed to the consumer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            corrCnt_q   <= '0;
            uncorrCnt_q <= '0;
        end else if (bus.cnt_clr) begin
            corrCnt_q   <= '0;
            uncorrCnt_q <= '0;
        end else if (xfer) begin
            if (outStatus_q == CORR && corrCnt_q != CNT_MAX)
                corrCnt_q <= corrCnt_q + 1'b1;
            if (outStatus_q == UNCORR && uncorrCnt_q != CNT_MAX)
                uncorrCnt_q <= uncorrCnt_q + 1'b1;
        end
    end

    assign bus.req_ready   = reqReady;
    assign bus.out_valid   = outValid_q;
    assign bus.out_id      = outId_q;
    assign bus.out_message = outMsg_q;
    assign bus.out_status  = outStatus_q;
    assign bus.corr_cnt    = corrCnt_q;
    assign bus.uncorr_cnt  = uncorrCnt_q;

endmodule

// File: tb/tb_an_decode_arbiter.sv
// ---------------------------------------------------------------------------
// tb_an_decode_arbiter
// Directed bench for an_decode_arbiter with an abstract reference model
// (round-robin pick, three-slot delay line, modular-arithmetic decode).
// ---------------------------------------------------------------------------
module tb_an_decode_arbiter;

    localparam int NREQ  = 4;
    localparam int CW_W  = 7;
    localparam int MSG_W = 3;
    localparam int CNT_W = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int assertions = 0;
    int failures   = 0;

    an_decode_arbiter_if #(.NREQ(NREQ), .CW_W(CW_W), .MSG_W(MSG_W), .CNT_W(CNT_W)) bus ();

    an_decode_arbiter #(.NREQ(NREQ), .CW_W(CW_W), .MSG_W(MSG_W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model state
    int mPtr = 0;
    bit mV [3];
    int mId [3];
    int mMsg [3];
    int mSt [3];
    int mCorr = 0;
    int mUncorr = 0;
    int mG;
    bit mAdv;
    int cmpG;
    int cmpReady;

    task automatic checkOutput(input string name, input int actual, input int expected);
        assertions++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [NREQ-1:0] valid,
                                 input logic [NREQ*CW_W-1:0] cws,
                                 input logic rdy);
        bus.req_valid    = valid;
        bus.req_codeword = cws;
        bus.out_ready    = rdy;
    endtask

    function automatic logic [NREQ*CW_W-1:0] packCw(input int c0, input int c1, input int c2, input int c3);
        return {CW_W'(c3), CW_W'(c2), CW_W'(c1), CW_W'(c0)};
    endfunction

    // Decode from first principles: find the +/-2^i whose residue matches.
    function automatic void decodeRef(input int x, output int msg, output int st);
        int r, e, y;
        r = x % 13;
        e = 0;
        for (int i = 0; i < 6; i++) begin
            if (((1 << i) % 13) == r) e = (1 << i);
            if (((13 - ((1 << i) % 13)) % 13) == r) e = -(1 << i);
        end
        if (r == 0) begin
            st  = 0;
            msg = (x / 13) % (1 << MSG_W);
        end else begin
            y = x - e;
            if (y < 0 || y > 91) begin
                st  = 2;
                msg = 0;
            end else begin
                st  = 1;
                msg = y / 13;
            end
        end
    endfunction

    function automatic int rrPick(input logic [NREQ-1:0] v, input int p);
        for (int k = 0; k < NREQ; k++)
            if (v[(p + k) % NREQ]) return (p + k) % NREQ;
        return -1;
    endfunction

    function automatic int oh2idx(input logic [NREQ-1:0] v);
        for (int k = 0; k < NREQ; k++)
            if (v[k]) return k;
        return -1;
    endfunction

    // Model advances on the same edges as the DUT, from inputs only.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mPtr = 0; mCorr = 0; mUncorr = 0;
            for (int i = 0; i < 3; i++) begin
                mV[i] = 1'b0; mId[i] = 0; mMsg[i] = 0; mSt[i] = 0;
            end
        end else begin
            mAdv = !mV[2] || bus.out_ready;
            if (bus.cnt_clr) begin
                mCorr = 0; mUncorr = 0;
            end else if (mV[2] && bus.out_ready) begin
                if (mSt[2] == 1 && mCorr < (1 << CNT_W) - 1) mCorr++;
                if (mSt[2] == 2 && mUncorr < (1 << CNT_W) - 1) mUncorr++;
            end
            if (mAdv) begin
                for (int i = 2; i > 0; i--) begin
                    mV[i] = mV[i-1]; mId[i] = mId[i-1]; mMsg[i] = mMsg[i-1]; mSt[i] = mSt[i-1];
                end
                mG = rrPick(bus.req_valid, mPtr);
                mV[0] = (mG >= 0);
                if (mG >= 0) begin
                    mId[0] = mG;
                    decodeRef(int'(bus.req_codeword[mG*CW_W +: CW_W]), mMsg[0], mSt[0]);
                    mPtr = (mG + 1) % NREQ;
                end
            end
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (!rst) begin
            mAdv     = !mV[2] || bus.out_ready;
            cmpG     = mAdv ? rrPick(bus.req_valid, mPtr) : -1;
            cmpReady = (cmpG >= 0) ? (1 << cmpG) : 0;
            checkOutput("model_req_ready", int'(bus.req_ready), cmpReady);
            checkOutput("model_out_valid", int'(bus.out_valid), int'(mV[2]));
            if (mV[2]) begin
                checkOutput("model_out_id", int'(bus.out_id), mId[2]);
                checkOutput("model_out_message", int'(bus.out_message), mMsg[2]);
                checkOutput("model_out_status", int'(bus.out_status), mSt[2]);
            end
            checkOutput("model_corr_cnt", int'(bus.corr_cnt), mCorr);
            checkOutput("model_uncorr_cnt", int'(bus.uncorr_cnt), mUncorr);
        end
    end

    task automatic sendReq(input int id, input int cw);
        logic [NREQ*CW_W-1:0] cws;
        logic [NREQ-1:0]      v;
        cws = '0;
        v   = '0;
        cws[id*CW_W +: CW_W] = CW_W'(cw);
        v[id] = 1'b1;
        applyStimulus(v, cws, 1'b1);
        @(negedge clk);
        checkOutput("accept_ready", int'(bus.req_ready), 1 << id);
        @(posedge clk); #1;
        applyStimulus('0, cws, 1'b1);
    endtask

    task automatic waitResult(input string tag, input int id, input int msg, input int st);
        int cycles;
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!bus.out_valid && cycles < 10);
        checkOutput({tag, "_latency"}, cycles, 3);
        checkOutput({tag, "_id"}, int'(bus.out_id), id);
        checkOutput({tag, "_message"}, int'(bus.out_message), msg);
        checkOutput({tag, "_status"}, int'(bus.out_status), st);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int order1 [5];
        int order2 [4];
        int cycles;
        order1 = '{0, 1, 2, 3, 0};
        order2 = '{2, 3, 0, 2};
        bus.cnt_clr = 1'b0;
        applyStimulus('0, '0, 1'b1);

        // Reset state
        repeat (2) @(negedge clk);
        checkOutput("rst_out_valid", int'(bus.out_valid), 0);
        checkOutput("rst_out_id", int'(bus.out_id), 0);
        checkOutput("rst_out_message", int'(bus.out_message), 0);
        checkOutput("rst_out_status", int'(bus.out_status), 0);
        checkOutput("rst_corr_cnt", int'(bus.corr_cnt), 0);
        checkOutput("rst_uncorr_cnt", int'(bus.uncorr_cnt), 0);
        checkOutput("rst_req_ready", int'(bus.req_ready), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Single decodes: clean, corrected (+4, -16), uncorrectable
        $display("[TB] single decodes");
        sendReq(0, 65);
        waitResult("cw65", 0, 5, 0);
        @(negedge clk);
        checkOutput("cw65_corr_cnt", int'(bus.corr_cnt), 0);
        checkOutput("cw65_uncorr_cnt", int'(bus.uncorr_cnt), 0);
        @(posedge clk); #1;
        sendReq(1, 69);
        waitResult("cw69", 1, 5, 1);
        @(negedge clk);
        checkOutput("cw69_corr_cnt", int'(bus.corr_cnt), 1);
        @(posedge clk); #1;
        sendReq(2, 49);
        waitResult("cw49", 2, 5, 1);
        @(negedge clk);
        checkOutput("cw49_corr_cnt", int'(bus.corr_cnt), 2);
        @(posedge clk); #1;
        sendReq(3, 127);
        waitResult("cw127", 3, 0, 2);
        @(negedge clk);
        checkOutput("cw127_uncorr_cnt", int'(bus.uncorr_cnt), 1);
        @(posedge clk); #1;

        // Round-robin with all requesters, then without requester 1
        $display("[TB] round robin");
        applyStimulus(4'b1111, packCw(13, 26, 39, 52), 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("rr_all_grant", oh2idx(bus.req_ready), order1[i]);
            @(posedge clk); #1;
        end
        applyStimulus(4'b1101, packCw(13, 26, 39, 52), 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("rr_drop1_grant", oh2idx(bus.req_ready), order2[i]);
            @(posedge clk); #1;
        end
        applyStimulus('0, packCw(13, 26, 39, 52), 1'b1);
        repeat (5) @(posedge clk);
        #1;

        // Stall with a full pipeline, then release
        $display("[TB] stall");
        applyStimulus(4'b1111, packCw(65, 69, 49, 127), 1'b0);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!bus.out_valid && cycles < 10);
        checkOutput("stall_fill_cycles", cycles, 4);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            checkOutput("stall_valid", int'(bus.out_valid), 1);
            checkOutput("stall_id", int'(bus.out_id), 3);
            checkOutput("stall_message", int'(bus.out_message), 0);
            checkOutput("stall_status", int'(bus.out_status), 2);
            checkOutput("stall_req_ready", int'(bus.req_ready), 0);
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        checkOutput("release_req_ready", int'(bus.req_ready), 4'b0100);
        checkOutput("drain0_id", int'(bus.out_id), 3);
        @(posedge clk); #1;
        applyStimulus('0, packCw(65, 69, 49, 127), 1'b1);
        @(negedge clk);
        checkOutput("drain1_id", int'(bus.out_id), 0);
        @(negedge clk);
        checkOutput("drain2_id", int'(bus.out_id), 1);
        @(negedge clk);
        checkOutput("drain3_id", int'(bus.out_id), 2);
        checkOutput("drain3_status", int'(bus.out_status), 1);
        repeat (4) @(posedge clk);
        #1;

        // Reset with three results in flight
        $display("[TB] reset in flight");
        applyStimulus(4'b1111, packCw(65, 69, 49, 127), 1'b1);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("pre_reset_valid", int'(bus.out_valid), 1);
        rst = 1'b1;
        applyStimulus('0, packCw(65, 69, 49, 127), 1'b1);
        #1;
        checkOutput("reset_out_valid", int'(bus.out_valid), 0);
        checkOutput("reset_corr_cnt", int'(bus.corr_cnt), 0);
        checkOutput("reset_uncorr_cnt", int'(bus.uncorr_cnt), 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checkOutput("post_reset_valid", int'(bus.out_valid), 0);
        end
        @(posedge clk); #1;

        // Clear colliding with a corrected transfer
        $display("[TB] counter clear");
        sendReq(1, 69);
        waitResult("clr_pre", 1, 5, 1);
        @(negedge clk);
        checkOutput("clr_pre_corr_cnt", int'(bus.corr_cnt), 1);
        @(posedge clk); #1;
        sendReq(1, 69);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!bus.out_valid && cycles < 10);
        checkOutput("clr_latency", cycles, 3);
        checkOutput("clr_status", int'(bus.out_status), 1);
        bus.cnt_clr = 1'b1;
        @(posedge clk); #1;
        bus.cnt_clr = 1'b0;
        @(negedge clk);
        checkOutput("clr_corr_cnt", int'(bus.corr_cnt), 0);
        checkOutput("clr_uncorr_cnt", int'(bus.uncorr_cnt), 0);

        repeat (4) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule

// File: doc/an_decode_arbiter.md
Name: an_decode_arbiter

Overview:
- Shares one pipelined AN-code (A=13) decoding datapath between NREQ requesters.
- Round-robin arbitration selects a codeword. A Barrett-reduction stage computes the residue, and a syndrome stage corrects a single ±2^i error and recovers the message.
- Each result returns with its requester id, a status code and saturating error counters.
- Sits between the codeword-receive logic and the message consumers.

Parameters:
- NREQ, 4, number of requesters (2..8)
- CW_W, 7, codeword width; holds 13*7=91
- MSG_W, 3, message width; valid messages 0..7
- CNT_W, 16, width of the statistics counters

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- req_valid  in  NREQ  per-requester codeword valid
- req_codeword  in  NREQ*CW_W  codewords; requester i uses bits [i*CW_W +: CW_W]
- req_ready  out  NREQ  per-requester accept, one-hot or zero
- out_valid  out  1  result valid
- out_ready  in  1  consumer accept
- out_id  out  $clog2(NREQ)  requester that owns the result
- out_message  out  MSG_W  decoded message
- out_status  out  2  00 clean, 01 corrected, 10 uncorrectable
- cnt_clr  in  1  synchronous clear of both counters
- corr_cnt  out  CNT_W  count of corrected results
- uncorr_cnt  out  CNT_W  count of uncorrectable results

Behaviour:
- Reset: all stage valids 0, round-robin pointer 0, out_valid 0, out_id/out_message/out_status 0, both counters 0, req_ready 0.
- Pipeline control:
  - Three stages S1, S2, S3. S3 drives the out_* ports.
  - adv = !s3_valid || out_ready. All stages move together when adv=1 and hold when adv=0.
  - Bubbles are not compressed.
- Arbitration:
  - When adv=1, grant goes to the first requester with req_valid set, searching from the pointer upward with wrap.
  - req_ready[g] = adv && req_valid[g]; req_ready is combinational from adv and req_valid.
  - On each accepted transfer, pointer <= g+1 mod NREQ. With no request, S1 loads a bubble and the pointer is unchanged.
- S1: registers x = codeword, the id, and q = (x*19) >> 8, where M=19 and s=8.
- S2: r = x - 13*q. If r >= 13, then r -= 13; one correction step suffices for x < 128. Registers r, x and id.
- S3, syndrome lookup: r -> offset e, with corrected value y = x - e.
  - 1->+1, 2->+2, 4->+4, 8->+8, 3->+16, 6->+32.
  - 12->-1, 11->-2, 9->-4, 5->-8, 10->-16, 7->-32.
  - r=0 gives e=0 and status 00.
  - Otherwise status 01, unless y < 0 or y > 91, in which case status 10.
  - y is computed in CW_W+2 signed bits.
  - out_message = y/13 for status 00/01, and 0 for status 10.
- Latency: 3 cycles from accept to out_valid with no stall. Throughput is 1 per cycle.
- Under stall (out_valid && !out_ready) all out_* ports are held stable and req_ready is 0.
- Counters:
  - Increment on the output transfer (out_valid && out_ready) by status, saturating at 2^CNT_W-1.
  - cnt_clr has priority over an increment in the same cycle.
- Reset mid-operation flushes all in-flight results; they are lost and never reported.

Decomposition:
- Package an_code_pkg holds: A=13, BARRETT_M=19, BARRETT_S=8, MAX_CW=91, status enum (CLEAN, CORR, UNCORR), and a syndrome offset function residue -> signed offset.
- Sub-module an_barrett_residue: 2-stage registered residue (S1/S2), with input x and enable, outputs r and a delayed x. It is instantiated once.

Test Plan:
- req0 sends 65 (13*5), out_ready=1 -> 3 cycles later: out_valid=1, id=0, message=5, status=00, counters unchanged.
- req1 sends 69 (65+4): residue 4 -> message=5, status=01, corr_cnt=1. req2 sends 49 (65-16): residue 10 -> message=5, status=01.
- req3 sends 127: residue 10 gives y=143 > 91 -> status=10, message=0, uncorr_cnt=1.
- All four req_valid held high with pointer=0 -> accepts in order 0,1,2,3,0. Drop req1 -> order continues 2,3,0,2.
- Pipeline full, out_ready=0 for 5 cycles -> outputs stable, req_ready=0. out_ready=1 -> three results drain in order, and a new accept happens in the same cycle.
- Assert rst while 3 results are in flight -> out_valid=0 immediately, counters 0, no stale result after release. Also: cnt_clr asserted together with a corrected transfer -> corr_cnt=0.
